cdda_stream_fifo: RTL

//  Parametrised CD-DA sample buffer for the MCD sub-CPU audio path. Buffers the byte stream

---
 rtl/cdda_stream_fifo.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cdda_stream_fifo.sv
// CD-DA byte buffer: prefill to START_LVL, then one CH x 16-bit frame per DAC tick with ramped gain.
// pcm_stb 2*CH+2 cycles after a fetching tick; no input backpressure (bytes dropped on full, ovr_flag).
module cdda_stream_fifo #(
    parameter int CH        = 2,
    parameter int AW        = 13,
    parameter int START_LVL = 4704,
    parameter int RAMP_LOG2 = 4
) (
    input  logic             clk_asic,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             next_sample,
    output logic [16*CH-1:0] pcm_out,
    output logic             pcm_stb,
    output logic             play_on,
    output logic [AW:0]      level,
    output logic             ovr_flag,
    output logic             udr_flag,
    output logic             tick_err
);
    localparam int              FB     = 2 * CH;
    localparam int              CW     = $clog2(FB + 1);
    localparam logic [AW:0]     DEPTH  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]     FB_LVL = (AW + 1)'(FB);
    localparam logic [AW:0]     START  = (AW + 1)'(START_LVL);
    localparam logic [CW-1:0]   FB_CNT = CW'(FB);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_FETCH} state_t;

    state_t                 state_q;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q, rd_addr;
    logic [AW:0]            level_q;
    logic [CW-1:0]          cnt_q;
    logic [7:0]             mem [0:(1<<AW)-1];
    logic [7:0]             rd_data_q;
    logic [FB-2:0][7:0]     buf_q;
    logic [16*CH-1:0]       raw_q, raw_d, pcm_q, pcm_d;
    logic                   stb_q, stb_d;
    logic [7:0]             gain_q, gain_d;
    logic [RAMP_LOG2-1:0]   step_q, step_d;
    logic                   ovr_q, udr_q, terr_q;
    logic                   tick_ok, wr_acc, reserve, fetch_done;

    function automatic logic [15:0] scale(input logic [15:0] s, input logic [7:0] g);
        logic signed [24:0] a, b, p;
        a = 25'($signed(s));
        b = 25'($signed({1'b0, g}));
        p = a * b;
        return 16'(p >>> 7);
    endfunction

    assign tick_ok    = next_sample && (state_q != S_FETCH);
    assign wr_acc     = wr_en && !flush && (level_q != DEPTH);
    assign reserve    = tick_ok && !flush && (state_q == S_PLAY) && (level_q >= FB_LVL);
    assign fetch_done = (state_q == S_FETCH) && (cnt_q == FB_CNT) && !flush;
    assign rd_addr    = rd_ptr_q + AW'(cnt_q);

    always_ff @(posedge clk_asic) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_comb begin
        gain_d = gain_q;
        step_d = step_q;
        if (tick_ok) begin
            step_d = step_q + RAMP_LOG2'(1);
            if (step_q == '1) begin
                if ((state_q != S_IDLE) && (gain_q < 8'd128)) begin
                    gain_d = gain_q + 8'd1;
                end else if ((state_q == S_IDLE) && (gain_q != 8'd0)) begin
                    gain_d = gain_q - 8'd1;
                end
            end
        end
        raw_d = fetch_done ? {rd_data_q, buf_q} : raw_q;
        pcm_d = '0;
        for (int n = 0; n < CH; n++) begin
            pcm_d[16*n +: 16] = scale(raw_d[16*n +: 16], gain_d);
        end
        // A tick that starts a fetch reports at fetch completion instead.
        stb_d = !flush && (fetch_done || (tick_ok && !reserve));
    end

    always_ff @(posedge clk_asic) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            raw_q    <= '0;
            pcm_q    <= '0;
            stb_q    <= 1'b0;
            gain_q   <= '0;
            step_q   <= '0;
            ovr_q    <= 1'b0;
            udr_q    <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            step_q <= step_d;
            gain_q <= gain_d;
            raw_q  <= raw_d;
            stb_q  <= stb_d;
            if (stb_d) begin
                pcm_q <= pcm_d;
            end
            if (wr_en && !flush && (level_q == DEPTH)) begin
                ovr_q <= 1'b1;
            end
            if (next_sample && (state_q == S_FETCH)) begin
                terr_q <= 1'b1;
            end
            if (flush) begin
                state_q  <= S_IDLE;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
                cnt_q    <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                level_q <= level_q + (AW + 1)'(wr_acc) - (reserve ? FB_LVL : (AW + 1)'(0));
                case (state_q)
                    S_IDLE: begin
                        if (tick_ok && (level_q >= START)) begin
                            state_q <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (tick_ok) begin
                            if (level_q >= FB_LVL) begin
                                state_q <= S_FETCH;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= S_IDLE;
                                udr_q   <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        // RAM data lags the issued address by one cycle, so byte k lands at cnt k+1.
                        for (int k = 0; k < FB - 1; k++) begin
                            if (cnt_q == CW'(k + 1)) begin
                                buf_q[k] <= rd_data_q;
                            end
                        end
                        if (cnt_q == FB_CNT) begin
                            state_q  <= S_PLAY;
                            rd_ptr_q <= rd_ptr_q + AW'(FB);
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pcm_out  = pcm_q;
    assign pcm_stb  = stb_q;
    assign play_on  = (state_q != S_IDLE);
    assign level    = level_q;
    assign ovr_flag = ovr_q;
    assign udr_flag = udr_q;
    assign tick_err = terr_q;

endmodule
